// File: rtl/ex_multicycle_ctrl_if.sv
// ex_multicycle_ctrl_if: E-stage op/hazard inputs and stall/flush/status outputs of the multi-cycle sequencer
interface ex_multicycle_ctrl_if;
  logic       FPUStartE;
  logic [2:0] FPUControlE;
  logic       MatmulStartE;
  logic       MatmulBusy;
  logic       PCSrcE;
  logic       LwStallD;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FPUValidE;
  logic       MatmulGo;
  logic       MatmulTimeout;
  modport master (
    output FPUStartE, FPUControlE, MatmulStartE, MatmulBusy, PCSrcE, LwStallD,
    input  StallF, StallD, StallE, FlushD, FlushE, FPUValidE, MatmulGo, MatmulTimeout
  );
  modport slave (
    input  FPUStartE, FPUControlE, MatmulStartE, MatmulBusy, PCSrcE, LwStallD,
    output StallF, StallD, StallE, FlushD, FlushE, FPUValidE, MatmulGo, MatmulTimeout
  );
endinterface

// File: rtl/ex_multicycle_ctrl.sv
// ex_multicycle_ctrl: holds FPU/matmul ops in EX until done and merges load-use stall with branch flush (clk, active-low sync reset, bus = slave side)
module ex_multicycle_ctrl #(
  parameter int FPU_LAT     = 3,
  parameter int FPU_DIV_LAT = 8,
  parameter int MM_TIMEOUT  = 1023
) (
  input logic clk,
  input logic reset,
  ex_multicycle_ctrl_if.slave bus
);
  localparam int WW = $clog2(MM_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FPU_RUN, MM_WAIT, MM_RUN} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, lat;
  logic [WW-1:0] wd, wd_n;
  logic to, to_n, wd_hit, stall_e, fpu_valid, mm_go;
  assign lat = bus.FPUControlE == 3'b011 ? 4'(FPU_DIV_LAT) : 4'(FPU_LAT);
  assign wd_hit = wd == WW'(MM_TIMEOUT);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      wd    <= '0;
      to    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wd    <= wd_n;
      to    <= to_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wd_n    = wd;
    to_n    = to;
    case (state)
      IDLE: begin
        if (bus.FPUStartE) begin
          if (lat > 4'd1) begin
            state_n = FPU_RUN;
            cnt_n   = lat - 4'd2;
          end
        end else if (bus.MatmulStartE) begin
          state_n = MM_WAIT;
          wd_n    = '0;
        end
      end
      FPU_RUN: begin
        if (cnt == 4'd0) state_n = IDLE;
        else cnt_n = cnt - 4'd1;
      end
      default: begin
        wd_n = wd + 1'b1;
        if (wd_hit) begin
          to_n    = 1'b1;
          state_n = IDLE;
        end else if (state == MM_WAIT && bus.MatmulBusy) state_n = MM_RUN;
        else if (state == MM_RUN && !bus.MatmulBusy) state_n = IDLE;
      end
    endcase
  end
  always_comb begin
    stall_e   = state == IDLE    ? (bus.FPUStartE ? lat > 4'd1 : bus.MatmulStartE) :
                state == FPU_RUN ? cnt != 4'd0 :
                state == MM_WAIT ? !wd_hit : bus.MatmulBusy && !wd_hit;
    fpu_valid = (state == IDLE && bus.FPUStartE && lat == 4'd1) || (state == FPU_RUN && cnt == 4'd0);
    mm_go     = state == IDLE && !bus.FPUStartE && bus.MatmulStartE;
  end
  // an op held in EX (stall_e) masks every flush so it is never cleared mid-flight
  assign bus.StallE        = reset & stall_e;
  assign bus.StallF        = reset & (stall_e | bus.LwStallD);
  assign bus.StallD        = reset & (stall_e | bus.LwStallD);
  assign bus.FlushD        = reset & bus.PCSrcE & ~stall_e;
  assign bus.FlushE        = reset & (bus.PCSrcE | bus.LwStallD) & ~stall_e;
  assign bus.FPUValidE     = reset & fpu_valid;
  assign bus.MatmulGo      = reset & mm_go;
  assign bus.MatmulTimeout = reset & to;
endmodule
